tx_code_modulator: RTL and testbench

- Transmit-side counterpart of the receive correlation path: generates the BPSK-coded ultrasonic burst that the rx correlator searches for.
- On a start request, it steps through a fixed pseudo-random chip code. Each chip emits CYCLES_PER_CHIP periods of a 10-sample sine carrier, either in phase (chip=1) or inverted (chip=0).
- After the code it emits a run of zero-valued guard samples.
- Sits between the tx control logic and the DAC sample interface. Paced by the same per-sample trigger used on the rx side.

---
 rtl/tx_code_modulator_if.sv | 23 ++
 rtl/tx_code_modulator.sv | 171 +++++++++++++++++
 tb/tb_tx_code_modulator.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tx_code_modulator_if.sv
// Sample-rate control and DAC-side signals of the tx code modulator.
// The controller/bench drives the master side; the modulator uses the slave side.
interface tx_code_modulator_if;
  logic               etx_en;
  logic               inew_sample_trig;
  logic               istart;
  logic               iabort;
  logic signed [15:0] odata_sample;
  logic               osample_valid;
  logic               obusy;
  logic               odone;
  logic [7:0]         ochip_index;

  modport master (
    output etx_en, inew_sample_trig, istart, iabort,
    input  odata_sample, osample_valid, obusy, odone, ochip_index
  );

  modport slave (
    input  etx_en, inew_sample_trig, istart, iabort,
    output odata_sample, osample_valid, obusy, odone, ochip_index
  );
endinterface

// File: rtl/tx_code_modulator.sv
// BPSK chip-code burst generator: per sample trigger emits one point of a
// 10-sample sine carrier, sign set by the current chip, followed by zero guard samples.
module tx_code_modulator #(
  parameter int                  CODE_LEN        = 31,
  parameter logic [CODE_LEN-1:0] CODE            = 31'h4B3E3715,
  parameter int                  CYCLES_PER_CHIP = 2,
  parameter int                  GUARD_SAMPLES   = 20
) (
  input logic               ctx_clk,
  input logic               rtx_rst,
  tx_code_modulator_if.slave bus
);

  localparam int DATA_W = 16;
  localparam logic [3:0] LAST_PHASE = 4'd9;
  localparam logic [3:0] LAST_CYCLE = 4'(CYCLES_PER_CHIP - 1);
  localparam logic [7:0] LAST_CHIP  = 8'(CODE_LEN - 1);
  localparam logic [9:0] LAST_GUARD = 10'(GUARD_SAMPLES - 1);

  typedef enum logic [1:0] {IDLE, SEND, GUARD, DONE} state_t;

  function automatic logic signed [DATA_W-1:0] carrier(input logic [3:0] ph);
    case (ph)
      4'd1, 4'd4: carrier = 16'sd9630;
      4'd2, 4'd3: carrier = 16'sd15582;
      4'd6, 4'd9: carrier = -16'sd9630;
      4'd7, 4'd8: carrier = -16'sd15582;
      default:    carrier = 16'sd0;
    endcase
  endfunction

  // Table never holds -32768, so negation cannot overflow.
  function automatic logic signed [DATA_W-1:0] apply_sign(input logic signed [DATA_W-1:0] v,
                                                          input logic chip);
    apply_sign = chip ? v : -v;
  endfunction

  state_t                    state_q, state_d;
  logic [3:0]                phase_q, phase_d;
  logic [3:0]                cycle_q, cycle_d;
  logic [7:0]                chip_q, chip_d;
  logic [9:0]                guard_q, guard_d;
  logic [CODE_LEN-1:0]       code_q, code_d;
  logic signed [DATA_W-1:0]  data_q, data_d;
  logic                      valid_q, valid_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic [7:0]                chip_idx_q, chip_idx_d;

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    cycle_d    = cycle_q;
    chip_d     = chip_q;
    guard_d    = guard_q;
    code_d     = code_q;
    data_d     = data_q;
    valid_d    = valid_q;
    busy_d     = busy_q;
    done_d     = done_q;
    chip_idx_d = chip_idx_q;

    // With the enable low everything, including a pending pulse, simply holds.
    if (bus.etx_en) begin
      valid_d = 1'b0;
      done_d  = 1'b0;
      if (bus.iabort) begin
        state_d = IDLE;
        phase_d = '0;
        cycle_d = '0;
        chip_d  = '0;
        guard_d = '0;
        data_d  = '0;
        busy_d  = 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            data_d = '0;
            if (bus.istart) begin
              state_d    = SEND;
              busy_d     = 1'b1;
              phase_d    = '0;
              cycle_d    = '0;
              chip_d     = '0;
              guard_d    = '0;
              code_d     = CODE;
              chip_idx_d = '0;
            end
          end
          SEND: begin
            if (bus.inew_sample_trig) begin
              data_d     = apply_sign(carrier(phase_q), code_q[CODE_LEN-1]);
              valid_d    = 1'b1;
              chip_idx_d = chip_q;
              if (phase_q == LAST_PHASE) begin
                phase_d = '0;
                if (cycle_q == LAST_CYCLE) begin
                  cycle_d = '0;
                  code_d  = code_q << 1;
                  if (chip_q == LAST_CHIP) begin
                    state_d = (GUARD_SAMPLES == 0) ? DONE : GUARD;
                  end else begin
                    chip_d = chip_q + 8'd1;
                  end
                end else begin
                  cycle_d = cycle_q + 4'd1;
                end
              end else begin
                phase_d = phase_q + 4'd1;
              end
            end
          end
          GUARD: begin
            if (bus.inew_sample_trig) begin
              data_d  = '0;
              valid_d = 1'b1;
              if (guard_q == LAST_GUARD) begin
                guard_d = '0;
                state_d = DONE;
              end else begin
                guard_d = guard_q + 10'd1;
              end
            end
          end
          DONE: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            data_d  = '0;
            state_d = IDLE;
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge ctx_clk or negedge rtx_rst) begin
    if (!rtx_rst) begin
      state_q    <= IDLE;
      phase_q    <= '0;
      cycle_q    <= '0;
      chip_q     <= '0;
      guard_q    <= '0;
      code_q     <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      chip_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      cycle_q    <= cycle_d;
      chip_q     <= chip_d;
      guard_q    <= guard_d;
      code_q     <= code_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      chip_idx_q <= chip_idx_d;
    end
  end

  assign bus.odata_sample  = data_q;
  assign bus.osample_valid = valid_q;
  assign bus.obusy         = busy_q;
  assign bus.odone         = done_q;
  assign bus.ochip_index   = chip_idx_q;

endmodule

// File: tb/tb_tx_code_modulator.sv
// Scoreboard bench for tx_code_modulator: default-parameter instance plus a
// small-code instance; expected samples are queued at trigger time and popped by a monitor.
module tb_tx_code_modulator;

  typedef struct {
    int data;
    int chip;
  } exp_t;

  localparam logic [30:0] CODE_A = 31'h4B3E3715;
  localparam logic [2:0]  CODE_S = 3'b101;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tx_code_modulator_if bus_a();
  tx_code_modulator_if bus_s();

  tx_code_modulator dut_a (
    .ctx_clk (clk),
    .rtx_rst (rst_n),
    .bus     (bus_a)
  );

  tx_code_modulator #(
    .CODE_LEN        (3),
    .CODE            (3'b101),
    .CYCLES_PER_CHIP (1),
    .GUARD_SAMPLES   (0)
  ) dut_s (
    .ctx_clk (clk),
    .rtx_rst (rst_n),
    .bus     (bus_s)
  );

  exp_t q_a[$];
  exp_t q_s[$];
  exp_t e_a, e_s;
  int   n_cmp = 0;
  int   n_err = 0;
  int   vcnt_a = 0, vcnt_s = 0, dcnt_a = 0, dcnt_s = 0;
  int   nsamp_a = 0, nsamp_s = 0;
  logic pv_a = 1'b0, pv_s = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int tbl(input int ph);
    case (ph)
      1, 4:    return 9630;
      2, 3:    return 15582;
      6, 9:    return -9630;
      7, 8:    return -15582;
      default: return 0;
    endcase
  endfunction

  function automatic exp_t exp_a(input int n);
    exp_t r;
    if (n >= 620) begin
      r.data = 0;
      r.chip = 30;
    end else begin
      r.chip = n / 20;
      r.data = CODE_A[30 - r.chip] ? tbl(n % 10) : -tbl(n % 10);
    end
    return r;
  endfunction

  function automatic exp_t exp_s(input int n);
    exp_t r;
    r.chip = n / 10;
    r.data = CODE_S[2 - r.chip] ? tbl(n % 10) : -tbl(n % 10);
    return r;
  endfunction

  // Monitor: pops one expectation per valid pulse and watches done pulses.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_a.osample_valid) begin
        vcnt_a++;
        check("a_expect_pending", q_a.size() > 0, 1);
        if (q_a.size() > 0) begin
          e_a = q_a.pop_front();
          check("a_sample", int'(bus_a.odata_sample), e_a.data);
          check("a_chip_index", bus_a.ochip_index, e_a.chip);
        end
      end
      if (bus_a.odone) begin
        dcnt_a++;
        check("a_done_follows_last_sample", pv_a, 1);
        check("a_busy_low_at_done", bus_a.obusy, 0);
      end
      pv_a = bus_a.osample_valid;

      if (bus_s.osample_valid) begin
        vcnt_s++;
        check("s_expect_pending", q_s.size() > 0, 1);
        if (q_s.size() > 0) begin
          e_s = q_s.pop_front();
          check("s_sample", int'(bus_s.odata_sample), e_s.data);
          check("s_chip_index", bus_s.ochip_index, e_s.chip);
        end
      end
      if (bus_s.odone) begin
        dcnt_s++;
        check("s_done_follows_last_sample", pv_s, 1);
        check("s_busy_low_at_done", bus_s.obusy, 0);
      end
      pv_s = bus_s.osample_valid;
    end
  end

  task automatic pulse_a(input bit push);
    @(negedge clk);
    bus_a.inew_sample_trig = 1'b1;
    if (push) begin
      q_a.push_back(exp_a(nsamp_a));
      nsamp_a++;
    end
    @(negedge clk);
    bus_a.inew_sample_trig = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_s();
    @(negedge clk);
    bus_s.inew_sample_trig = 1'b1;
    q_s.push_back(exp_s(nsamp_s));
    nsamp_s++;
    @(negedge clk);
    bus_s.inew_sample_trig = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic start_a();
    @(negedge clk);
    bus_a.istart = 1'b1;
    @(negedge clk);
    bus_a.istart = 1'b0;
    nsamp_a = 0;
  endtask

  logic signed [15:0] held;

  initial begin
    bus_a.etx_en = 1'b1; bus_a.inew_sample_trig = 1'b0; bus_a.istart = 1'b0; bus_a.iabort = 1'b0;
    bus_s.etx_en = 1'b1; bus_s.inew_sample_trig = 1'b0; bus_s.istart = 1'b0; bus_s.iabort = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_data", int'(bus_a.odata_sample), 0);
    check("rst_valid", bus_a.osample_valid, 0);
    check("rst_busy", bus_a.obusy, 0);
    check("rst_done", bus_a.odone, 0);
    check("rst_chip_index", bus_a.ochip_index, 0);
    check("rst_s_busy", bus_s.obusy, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Full burst; start coincides with a trigger, which must not produce a sample.
    vcnt_a = 0; dcnt_a = 0; nsamp_a = 0;
    @(negedge clk);
    bus_a.istart = 1'b1;
    bus_a.inew_sample_trig = 1'b1;
    @(negedge clk);
    bus_a.istart = 1'b0;
    bus_a.inew_sample_trig = 1'b0;
    check("start_busy", bus_a.obusy, 1);
    check("start_trig_no_sample", bus_a.osample_valid, 0);
    repeat (2) @(negedge clk);

    for (int i = 0; i < 640; i++) begin
      pulse_a(1'b1);
      if (i == 99) begin
        @(negedge clk);
        bus_a.istart = 1'b1;
        @(negedge clk);
        bus_a.istart = 1'b0;
        check("restart_ignored_busy", bus_a.obusy, 1);
      end
      if (i == 199) begin
        held = bus_a.odata_sample;
        bus_a.etx_en = 1'b0;
        for (int k = 0; k < 50; k++) begin
          bus_a.inew_sample_trig = (k % 4 == 0);
          @(negedge clk);
          check("dis_valid", bus_a.osample_valid, 0);
          check("dis_data_frozen", int'(bus_a.odata_sample), int'(held));
          check("dis_busy", bus_a.obusy, 1);
        end
        bus_a.inew_sample_trig = 1'b0;
        bus_a.etx_en = 1'b1;
      end
    end
    repeat (4) @(negedge clk);
    check("burst_valid_count", vcnt_a, 640);
    check("burst_done_count", dcnt_a, 1);
    check("burst_queue_drained", q_a.size(), 0);
    check("burst_busy_end", bus_a.obusy, 0);
    check("burst_chip_hold", bus_a.ochip_index, 30);

    // Abort at sample 300, with start asserted at the same time.
    vcnt_a = 0; dcnt_a = 0;
    start_a();
    for (int i = 0; i < 300; i++) pulse_a(1'b1);
    @(negedge clk);
    bus_a.iabort = 1'b1;
    bus_a.istart = 1'b1;
    @(negedge clk);
    bus_a.iabort = 1'b0;
    bus_a.istart = 1'b0;
    check("abort_busy", bus_a.obusy, 0);
    check("abort_data", int'(bus_a.odata_sample), 0);
    check("abort_valid", bus_a.osample_valid, 0);
    repeat (5) @(negedge clk);
    check("abort_no_done", dcnt_a, 0);
    check("abort_stays_idle", bus_a.obusy, 0);
    check("abort_valid_count", vcnt_a, 300);

    // Fresh start after abort, then asynchronous reset mid-burst.
    start_a();
    for (int i = 0; i < 25; i++) pulse_a(1'b1);
    check("pre_reset_chip", bus_a.ochip_index, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("areset_data", int'(bus_a.odata_sample), 0);
    check("areset_busy", bus_a.obusy, 0);
    check("areset_valid", bus_a.osample_valid, 0);
    check("areset_chip", bus_a.ochip_index, 0);
    q_a.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_reset_no_done", dcnt_a, 0);
    check("post_reset_busy", bus_a.obusy, 0);

    // Short code, no guard: +table, -table, +table then done.
    vcnt_s = 0; dcnt_s = 0; nsamp_s = 0;
    @(negedge clk);
    bus_s.istart = 1'b1;
    @(negedge clk);
    bus_s.istart = 1'b0;
    check("s_start_busy", bus_s.obusy, 1);
    for (int i = 0; i < 30; i++) pulse_s();
    repeat (3) @(negedge clk);
    check("s_valid_count", vcnt_s, 30);
    check("s_done_count", dcnt_s, 1);
    check("s_queue_drained", q_s.size(), 0);
    check("s_busy_end", bus_s.obusy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
